// File: rtl/fpu_pkg.sv
// fpu_pkg: shared sqrt operand classes, IEEE-754 single constants and the issue-time classifier
package fpu_pkg;
  typedef enum logic [1:0] {NORMAL, ZERO, NAN, PINF} sq_cls_t;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  function automatic sq_cls_t classify_sqrt(input logic [31:0] x);
    return x[30:23] == 8'h00 ? ZERO :
           x[30:23] == FP_EXP_MAX ? ((x[22:0] != '0 || x[31]) ? NAN : PINF) :
           x[31] ? NAN : NORMAL;
  endfunction
endpackage

// File: rtl/fsqrt_res_fifo.sv
// fsqrt_res_fifo: DEPTH x W result FIFO (clk, rstn async low, clr sync, push/din, pop/dout head, count)
module fsqrt_res_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 37
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd, wr_nxt, rd_nxt;
  assign wr_nxt = wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
  assign rd_nxt = rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
  assign dout = count != '0 ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (push && !clr) mem[wr] <= din;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (clr) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr_nxt;
      if (pop) rd <= rd_nxt;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fsqrt_ctrl.sv
// fsqrt_ctrl: fsqrt issue/collect (clk, rstn, flush; in_valid/in_ready/in_x/in_tag -> sq_x; sq_y -> FIFO -> out_valid/out_ready/out_y/out_tag)
module fsqrt_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT = 3,
  parameter int DEPTH = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sq_x,
  input  logic [31:0]      sq_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + LAT + 1);
  logic [LAT-1:0] v;
  logic [LAT-1:0] sgn_q;
  logic [TAG_W-1:0] tag_q [LAT];
  sq_cls_t cls_q [LAT];
  logic [CW-1:0] count;
  logic [SW-1:0] occ;
  logic fire, pop, push;
  logic [31:0] res;
  logic [31+TAG_W:0] dout;
  assign sq_x = in_x;
  always_comb begin
    occ = SW'(count);
    for (int i = 0; i < LAT; i++) occ = occ + SW'(v[i]);
  end
  assign in_ready = rstn & ~flush & (occ < SW'(DEPTH));
  assign fire = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~flush;
  assign push = v[LAT-1];
  assign out_valid = count != '0;
  assign {out_y, out_tag} = dout;
  always_comb
    res = cls_q[LAT-1] == ZERO ? {sgn_q[LAT-1], 31'b0} :
          cls_q[LAT-1] == NAN ? FP_QNAN :
          cls_q[LAT-1] == PINF ? FP_PINF : sq_y;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      v <= '0;
      sgn_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
        cls_q[i] <= NORMAL;
      end
    end else begin
      v[0] <= fire;
      sgn_q[0] <= in_x[31];
      tag_q[0] <= in_tag;
      cls_q[0] <= classify_sqrt(in_x);
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1] & ~flush;
        sgn_q[i] <= sgn_q[i-1];
        tag_q[i] <= tag_q[i-1];
        cls_q[i] <= cls_q[i-1];
      end
    end
  fsqrt_res_fifo #(.DEPTH(DEPTH), .W(32 + TAG_W)) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .push (push),
    .din  ({res, tag_q[LAT-1]}),
    .pop  (pop),
    .dout (dout),
    .count(count)
  );
endmodule
